// File: rtl/arm_pkg.sv
// Shared constants and types for the ARM pipeline stages.
package arm_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC  = 32'h0000_0000;
  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam word_t PC_STEP   = 32'h0000_0004;

  // Branch targets are word aligned; the low two bits are simply dropped.
  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory bus between the fetch stage and a zero-latency memory.
// The fetch stage presents the address; the memory answers in the same cycle.
interface if_stage_if;
  import arm_pkg::*;

  word_t imem_addr;
  word_t imem_instr;

  // Fetch stage side: drives the address, consumes the returned word.
  modport master (
    output imem_addr,
    input  imem_instr
  );

  // Memory side: consumes the address, returns the word.
  modport slave (
    input  imem_addr,
    output imem_instr
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: captures PC+4 and the fetched word, with hold
// (hazard stall) and flush (branch redirect) controls. Flush wins over hold.
module if_id_reg
  import arm_pkg::*;
#(
  parameter word_t NOP_INSTR_P = NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold,
  input  logic  flush,
  input  word_t pc_in,
  input  word_t instr_in,
  output word_t pc,
  output word_t instr,
  output logic  valid
);

  // Pipeline register: flush inserts a bubble, hold keeps contents, else load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      instr <= NOP_INSTR_P;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= '0;
      instr <= NOP_INSTR_P;
      valid <= 1'b0;
    end else if (!hold) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, drives the instruction memory address
// and loads the returned word into the IF/ID register. A taken branch from EXE
// redirects the PC and flushes IF/ID; a hazard freeze holds everything.
// Optional feature macro: IF_FETCH_STATS_EN adds fetch_cnt / bubble_cnt outputs.
module if_stage
  import arm_pkg::*;
#(
  parameter word_t RESET_PC_P  = RESET_PC,
  parameter word_t NOP_INSTR_P = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        branch_taken,
  input  word_t       branch_addr,
  if_stage_if.master  imem,
  output word_t       if_id_pc,
  output word_t       if_id_instr,
  output logic        if_id_valid
`ifdef IF_FETCH_STATS_EN
  ,
  output word_t       fetch_cnt,
  output word_t       bubble_cnt
`endif
);

  word_t pc_reg;
  word_t pc_next;
  word_t pc_plus4;
  logic  advance;

  assign pc_plus4 = pc_reg + PC_STEP;
  assign advance  = !branch_taken && !freeze;

  // Redirect mux: branch beats freeze, freeze beats sequential advance.
  always_comb begin
    pc_next = pc_reg;
    if (branch_taken) begin
      pc_next = align_word(branch_addr);
    end else if (!freeze) begin
      pc_next = pc_plus4;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC_P;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign imem.imem_addr = pc_reg;

  if_id_reg #(
    .NOP_INSTR_P (NOP_INSTR_P)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (freeze),
    .flush    (branch_taken),
    .pc_in    (pc_plus4),
    .instr_in (imem.imem_instr),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

`ifdef IF_FETCH_STATS_EN
  word_t fetch_cnt_reg;
  word_t bubble_cnt_reg;

  // Fetch statistics: a bubble edge is any freeze or flush edge, counted once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else if (advance) begin
      fetch_cnt_reg  <= fetch_cnt_reg + 32'd1;
    end else begin
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`else
  logic advance_unused;
  assign advance_unused = advance;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage. Instruction memory returns 0xEA000000 + addr
// so every fetched word identifies its address.
module tb_if_stage;
  import arm_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  freeze = 1'b0;
  logic  branch_taken = 1'b0;
  word_t branch_addr = '0;
  word_t if_id_pc;
  word_t if_id_instr;
  logic  if_id_valid;
`ifdef IF_FETCH_STATS_EN
  word_t fetch_cnt;
  word_t bubble_cnt;
`endif

  int checks = 0;
  int failures = 0;

  if_stage_if bus ();

  assign bus.imem_instr = 32'hEA00_0000 + bus.imem_addr;

  if_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus.master),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
`ifdef IF_FETCH_STATS_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle outputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input word_t addr, input word_t pc,
                     input word_t instr, input logic valid);
    checks++;
    if (bus.imem_addr !== addr || if_id_pc !== pc || if_id_instr !== instr ||
        if_id_valid !== valid) begin
      failures++;
      $display("FAIL %s: got addr=%h pc=%h instr=%h valid=%b, want addr=%h pc=%h instr=%h valid=%b",
               name, bus.imem_addr, if_id_pc, if_id_instr, if_id_valid,
               addr, pc, instr, valid);
    end else begin
      $display("ok   %s: addr=%h pc=%h instr=%h valid=%b", name, bus.imem_addr,
               if_id_pc, if_id_instr, if_id_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    chk("reset_state", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk("adv1", 32'h4, 32'h4, 32'hEA00_0000, 1'b1);
    step(); chk("adv2", 32'h8, 32'h8, 32'hEA00_0004, 1'b1);
    step(); chk("adv3", 32'hC, 32'hC, 32'hEA00_0008, 1'b1);
  endtask

  task automatic test_freeze();
    step(); chk("adv4", 32'h10, 32'h10, 32'hEA00_000C, 1'b1);
    freeze = 1'b1;
    step(); chk("freeze1", 32'h10, 32'h10, 32'hEA00_000C, 1'b1);
    step(); chk("freeze2", 32'h10, 32'h10, 32'hEA00_000C, 1'b1);
    freeze = 1'b0;
    step(); chk("unfreeze", 32'h14, 32'h14, 32'hEA00_0010, 1'b1);
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    branch_addr  = 32'h3C;
    step(); chk("branch_flush", 32'h3C, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    step(); chk("branch_target", 32'h40, 32'h40, 32'hEA00_003C, 1'b1);
  endtask

  task automatic test_branch_freeze();
    branch_taken = 1'b1;
    freeze       = 1'b1;
    branch_addr  = 32'h13;
    step(); chk("br_frz_align", 32'h10, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    freeze       = 1'b0;
    step(); chk("br_frz_next", 32'h14, 32'h14, 32'hEA00_0010, 1'b1);
  endtask

  task automatic test_async_reset();
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    step(); chk("to_0x40", 32'h40, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    step(); chk("at_0x44", 32'h44, 32'h44, 32'hEA00_0040, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("release_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    step(); chk("after_release", 32'h4, 32'h4, 32'hEA00_0000, 1'b1);
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFF;
    step(); chk("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    step(); chk("wrap", 32'h0, 32'h0, 32'hE9FF_FFFC, 1'b1);
    step(); chk("after_wrap", 32'h4, 32'h4, 32'hEA00_0000, 1'b1);
  endtask

`ifdef IF_FETCH_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
      failures++;
      $display("FAIL stats_reset: got fetch=%0d bubble=%0d, want 0 0", fetch_cnt, bubble_cnt);
    end else begin
      $display("ok   stats_reset: fetch=%0d bubble=%0d", fetch_cnt, bubble_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    freeze = 1'b1;
    step(); step();
    freeze = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    branch_taken = 1'b0;
    checks++;
    if (fetch_cnt !== 32'd5 || bubble_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stats_counts: got fetch=%0d bubble=%0d, want 5 3", fetch_cnt, bubble_cnt);
    end else begin
      $display("ok   stats_counts: fetch=%0d bubble=%0d", fetch_cnt, bubble_cnt);
    end
    chk("stats_branch", 32'h100, 32'h0, 32'h0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_async_reset();
    test_wrap();
`ifdef IF_FETCH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
